// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM plus ALU and immediate decode for the
// multicycle RV32I datapath. Sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux select.
// Optional feature: define MC_CTRL_MEM_WAIT_EN to make FETCH, MEMREAD and
// MEMWRITE stall on mem_ready; without it mem_ready is ignored.
// ALUCTRL_W must be >= 3; at >= 4 sra gets its own code (8).
module multicycle_control #(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 instr_done,
  output logic                 illegal_op
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       mem_ok;
  logic       legal_op;
  logic       pcupdate;
  logic       branch;
  logic [1:0] aluop;
  logic       irwrite_s;
  logic       memwrite_s;
  logic       regwrite_s;
  logic       retire_state;
  logic [3:0] alu_code;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  // Memory always completes in one cycle; the handshake input is a no-op.
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok           = 1'b1;
`endif

  assign legal_op = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
                    (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL) ||
                    (op == OP_LUI);

  // State register; reset drops the FSM straight back to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  // Next-state decode; memory states hold while the access is outstanding.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = mem_ok ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECR;
          OP_ITYPE:          next_state = EXECI;
          OP_BRANCH:         next_state = BRANCH;
          OP_JAL:            next_state = JAL;
          OP_LUI:            next_state = LUI;
          default:           next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = mem_ok ? MEMWB : MEMREAD;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = mem_ok ? FETCH : MEMWRITE;
      EXECR:    next_state = ALUWB;
      EXECI:    next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BRANCH:   next_state = FETCH;
      JAL:      next_state = ALUWB;
      LUI:      next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  end

  // Moore outputs per state; unlisted fields stay at zero.
  always_comb begin
    pcupdate   = 1'b0;
    branch     = 1'b0;
    aluop      = 2'b00;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    case (state)
      FETCH: begin
        irwrite_s = mem_ok;
        pcupdate  = mem_ok;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        // Precompute the branch target from OldPC + ImmExt.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc  = 2'b01;
        regwrite_s = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = 2'b10;
      end
      ALUWB:    regwrite_s = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
      end
      LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      default: ;
    endcase
  end

  // Immediate format depends only on the opcode.
  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
      OP_LUI:    ImmSrc = 3'b100;
      default:   ImmSrc = 3'b000;
    endcase
  end

  // ALU operation decode; sra only has a distinct code when the bus can carry it.
  always_comb begin
    alu_code = 4'd0;
    case (aluop)
      2'b01: alu_code = 4'd1;
      2'b10: begin
        case (funct3)
          3'b000:  alu_code = (op[5] && funct7b5) ? 4'd1 : 4'd0;
          3'b001:  alu_code = 4'd6;
          3'b010:  alu_code = 4'd5;
          3'b100:  alu_code = 4'd4;
          3'b101:  alu_code = (funct7b5 && (ALUCTRL_W >= 4)) ? 4'd8 : 4'd7;
          3'b110:  alu_code = 4'd3;
          3'b111:  alu_code = 4'd2;
          default: alu_code = 4'd0;
        endcase
      end
      default: alu_code = 4'd0;
    endcase
  end

  assign ALUControl = ALUCTRL_W'(alu_code);

  // bne inverts the sense of the zero flag via funct3[0].
  assign retire_state = (state == MEMWB) || (state == MEMWRITE) ||
                        (state == ALUWB) || (state == BRANCH);
  assign PCWrite    = rst_n & (pcupdate | (branch & (zero ^ funct3[0])));
  assign IRWrite    = rst_n & irwrite_s;
  assign MemWrite   = rst_n & memwrite_s;
  assign RegWrite   = rst_n & regwrite_s;
  assign instr_done = rst_n & retire_state & (next_state == FETCH);
  assign illegal_op = rst_n & (state == DECODE) & ~legal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: expected per-cycle state and
// control vectors are queued when an instruction is issued and popped as the
// DUT steps through it. A second instance with ALUCTRL_W=4 checks sra coding.
module tb_multicycle_control;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                         S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                         S_BRANCH = 4'd9, S_JAL = 4'd10, S_LUI = 4'd11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, instr_done, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [2:0] ALUControl;

  logic       PCWrite4, AdrSrc4, IRWrite4, MemWrite4, RegWrite4, instr_done4, illegal_op4;
  logic [1:0] ResultSrc4, ALUSrcA4, ALUSrcB4;
  logic [2:0] ImmSrc4;
  logic [3:0] ALUControl4;

  logic [19:0] obs3;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [19:0] ctl;
    logic [3:0]  alu4;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_control #(.ALUCTRL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  multicycle_control #(.ALUCTRL_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite4), .AdrSrc(AdrSrc4), .IRWrite(IRWrite4), .MemWrite(MemWrite4),
    .RegWrite(RegWrite4), .ResultSrc(ResultSrc4), .ALUSrcA(ALUSrcA4),
    .ALUSrcB(ALUSrcB4), .ImmSrc(ImmSrc4), .ALUControl(ALUControl4),
    .instr_done(instr_done4), .illegal_op(illegal_op4)
  );

  assign obs3 = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ImmSrc, 1'b0, ALUControl, instr_done, illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  // Reference Moore table: {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,
  // ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl[3:0],instr_done,illegal_op}
  function automatic logic [19:0] model(input logic [3:0] st, input logic [6:0] o,
                                        input logic [2:0] f3, input logic z,
                                        input logic [3:0] alu_ex, input logic last,
                                        input logic ill);
    logic pcw, adr, irw, mw, rw;
    logic [1:0] res, sa, sbs;
    logic [3:0] alu;
    pcw = 0; adr = 0; irw = 0; mw = 0; rw = 0;
    res = 0; sa = 0; sbs = 0; alu = 0;
    case (st)
      S_FETCH:    begin irw = 1; pcw = 1; sbs = 2; res = 2; end
      S_DECODE:   begin sa = 1; sbs = 1; end
      S_MEMADR:   begin sa = 2; sbs = 1; end
      S_MEMREAD:  adr = 1;
      S_MEMWB:    begin res = 1; rw = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_EXECR:    begin sa = 2; alu = alu_ex; end
      S_EXECI:    begin sa = 2; sbs = 1; alu = alu_ex; end
      S_ALUWB:    rw = 1;
      S_BRANCH:   begin sa = 2; alu = 4'd1; pcw = z ^ f3[0]; end
      S_JAL:      begin sa = 1; sbs = 2; pcw = 1; end
      S_LUI:      begin sa = 3; sbs = 1; end
      default: ;
    endcase
    return {pcw, adr, irw, mw, rw, res, sa, sbs, imm_of(o), alu, last, ill};
  endfunction

  // Issue one instruction starting in FETCH (just after a rising edge),
  // queue its expected cycles, then step and compare each one.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input logic [3:0] alu_ex,
                           input logic [3:0] alu_ex4);
    logic [3:0] seq[$];
    logic ill;
    exp_t e;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    case (o)
      7'b0000011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMREAD); seq.push_back(S_MEMWB); end
      7'b0100011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWRITE); end
      7'b0110011: begin seq.push_back(S_EXECR); seq.push_back(S_ALUWB); end
      7'b0010011: begin seq.push_back(S_EXECI); seq.push_back(S_ALUWB); end
      7'b1100011: seq.push_back(S_BRANCH);
      7'b1101111: begin seq.push_back(S_JAL); seq.push_back(S_ALUWB); end
      7'b0110111: begin seq.push_back(S_LUI); seq.push_back(S_ALUWB); end
      default: ;
    endcase
    ill = (seq.size() == 2);
    for (int i = 0; i < seq.size(); i++) begin
      e.st   = seq[i];
      e.ctl  = model(seq[i], o, f3, z, alu_ex, (i == seq.size() - 1) && !ill, ill && (i == 1));
      e.alu4 = model(seq[i], o, f3, z, alu_ex4, 1'b0, 1'b0)[5:2];
      sb.push_back(e);
    end
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      check({name, "/state"}, 32'(dut.state), 32'(e.st));
      check({name, "/ctl"}, 32'(obs3), 32'(e.ctl));
      check({name, "/alu4"}, 32'(ALUControl4), 32'(e.alu4));
      @(posedge clk);
      #1;
    end
  endtask

  // I-type ALU ops by funct3 (funct7b5 set only on 000 and 101 cases below).
  logic [3:0] itab3 [8] = '{4'd0, 4'd6, 4'd5, 4'd0, 4'd4, 4'd7, 4'd3, 4'd2};

  initial begin
    rst_n = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    #2 rst_n = 1'b0;

    // Reset hold: FETCH with write enables gated off.
    repeat (3) begin
      @(negedge clk);
      check("rst/state", 32'(dut.state), 32'(S_FETCH));
      check("rst/irwrite", 32'(IRWrite), 32'd0);
      check("rst/pcwrite", 32'(PCWrite), 32'd0);
      check("rst/done", 32'(instr_done), 32'd0);
      check("rst/alusrcb", 32'(ALUSrcB), 32'd2);
      check("rst/resultsrc", 32'(ResultSrc), 32'd2);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr("lw",   7'b0000011, 3'b010, 1'b0, 1'b0, 4'd0, 4'd0);
    run_instr("beq",  7'b1100011, 3'b000, 1'b0, 1'b1, 4'd0, 4'd0);
    run_instr("bne1", 7'b1100011, 3'b001, 1'b0, 1'b1, 4'd0, 4'd0);
    run_instr("bne0", 7'b1100011, 3'b001, 1'b0, 1'b0, 4'd0, 4'd0);
    run_instr("beq0", 7'b1100011, 3'b000, 1'b0, 1'b0, 4'd0, 4'd0);
    run_instr("sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 4'd1, 4'd1);
    run_instr("add",  7'b0110011, 3'b000, 1'b0, 1'b0, 4'd0, 4'd0);
    run_instr("sra",  7'b0110011, 3'b101, 1'b1, 1'b0, 4'd7, 4'd8);
    run_instr("srai", 7'b0010011, 3'b101, 1'b1, 1'b0, 4'd7, 4'd8);
    for (int f = 0; f < 8; f++) begin
      // addi with funct7b5=1 must still add because op[5]=0.
      run_instr("itype", 7'b0010011, 3'(f), (f == 0), 1'b0, itab3[f], itab3[f]);
    end
    run_instr("sw",   7'b0100011, 3'b010, 1'b0, 1'b0, 4'd0, 4'd0);
    run_instr("jal",  7'b1101111, 3'b000, 1'b0, 1'b0, 4'd0, 4'd0);
    run_instr("lui",  7'b0110111, 3'b000, 1'b0, 1'b0, 4'd0, 4'd0);
    run_instr("ill",  7'b1111111, 3'b000, 1'b0, 1'b0, 4'd0, 4'd0);
    run_instr("ill0", 7'b0000000, 3'b000, 1'b0, 1'b0, 4'd0, 4'd0);

    // Reset during sw address phase: store must never issue.
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("midrst/pre", 32'(dut.state), 32'(S_MEMADR));
    rst_n = 1'b0;
    #1;
    check("midrst/state", 32'(dut.state), 32'(S_FETCH));
    check("midrst/wen", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("midrst/hold", 32'(dut.state), 32'(S_FETCH));
      check("midrst/wen_hold", 32'({PCWrite, IRWrite, MemWrite, RegWrite, instr_done}), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef MC_CTRL_MEM_WAIT_EN
    // Wait states in FETCH and MEMWRITE.
    op = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b0;
    @(negedge clk);
    check("wait/fetch_ir", 32'({IRWrite, PCWrite}), 32'd0);
    @(posedge clk); #1;
    check("wait/fetch_hold", 32'(dut.state), 32'(S_FETCH));
    mem_ready = 1'b1;
    @(negedge clk);
    check("wait/fetch_go", 32'({IRWrite, PCWrite}), 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    check("wait/memwrite", 32'(dut.state), 32'(S_MEMWRITE));
    mem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("wait/mw_state", 32'(dut.state), 32'(S_MEMWRITE));
      check("wait/mw_we", 32'({MemWrite, instr_done}), 32'd2);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("wait/mw_last", 32'({MemWrite, instr_done}), 32'd3);
    @(posedge clk); #1;
    check("wait/back_fetch", 32'(dut.state), 32'(S_FETCH));
`else
    // Without the wait option, mem_ready low must not stall anything.
    mem_ready = 1'b0;
    run_instr("lw_nowait", 7'b0000011, 3'b010, 1'b0, 1'b0, 4'd0, 4'd0);
    run_instr("sw_nowait", 7'b0100011, 3'b010, 1'b0, 1'b0, 4'd0, 4'd0);
    mem_ready = 1'b1;
`endif

    @(negedge clk);
    check("end/state", 32'(dut.state), 32'(S_FETCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control unit for the multicycle RV32I datapath: a Moore finite-state machine (FSM) that sequences fetch, decode, execute, memory and write-back over several cycles, plus the combinational ALU and immediate decode. It sits beside the shared-memory datapath and drives all of its enables and mux selects. It generalises the single-cycle controller in three ways: a wider, parametrised ALU-control encoding, added instructions (bne, lui, jal) and an optional memory wait handshake.

## Interface
- ALUCTRL_W, 3, ALUControl width; must be ≥3. When ≥4, sra is given its own code.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instruction[6:0], from the instruction register
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete; used only under MC_CTRL_MEM_WAIT_EN
- PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  datapath enables and selects
- ResultSrc  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  ALU A input: 00 PC, 01 OldPC, 10 RD1, 11 zero
- ALUSrcB  out  2  ALU B input: 00 RD2, 01 ImmExt, 10 constant 4
- ImmSrc  out  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl  out  ALUCTRL_W  ALU operation
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
- State register, 4 bits. Encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11.
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR (op 0000011 or 0100011), EXECR (0110011), EXECI (0010011), BRANCH (1100011), JAL (1101111) or LUI (0110111).
  - DECODE → FETCH for any other opcode, with illegal_op pulsed.
  - MEMADR → MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECR, EXECI, JAL, LUI → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH → FETCH.
  - Unused state codes → FETCH.
- Moore outputs per state. Any field not listed is 0.
  - FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01. This computes the branch target.
  - MEMADR: ALUSrcA=10, ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUOp=10.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: RegWrite=1.
  - BRANCH: ALUSrcA=10, ALUOp=01, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
  - LUI: ALUSrcA=11, ALUSrcB=01.
- PCWrite = PCUpdate | (Branch & (zero ^ funct3[0])). beq is taken on zero=1; bne is taken on zero=0.
- ImmSrc is decoded from op, independent of state:
  - 0100011 → 001; 1100011 → 010; 1101111 → 011; 0110111 → 100; all others → 000.
- ALUControl:
  - ALUOp 00 → add 0.
  - ALUOp 01 → sub 1.
  - ALUOp 10, decoded on funct3:
    - 000: sub if op[5]&funct7b5, else add.
    - 001: sll 6.
    - 010: slt 5.
    - 100: xor 4.
    - 101: srl 7. When funct7b5=1 and ALUCTRL_W≥4, sra 8 instead.
    - 110: or 3.
    - 111: and 2.
    - 011: add.
  - Codes are zero-extended to ALUCTRL_W.
- instr_done=1 on the cycle the state goes from MEMWB, MEMWRITE, ALUWB or BRANCH to FETCH.

## Timing
- Reset:
  - rst_n low forces state=FETCH immediately.
  - PCWrite, IRWrite, RegWrite and MemWrite are gated to 0 combinationally while rst_n=0.
  - instr_done and illegal_op read 0 during reset.
  - Other outputs take their FETCH values.
- Instruction latency without wait states:
  - lw 5 cycles.
  - sw, R-type, I-type ALU, jal and lui 4 cycles.
  - beq/bne 3 cycles.
  - Illegal opcode 2 cycles.
- Reset asserted mid-instruction abandons the instruction. No write enable is asserted after rst_n falls.
- Outputs are purely state- and input-combinational. There is no output registering.

## Configuration
- MC_CTRL_MEM_WAIT_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold their state while mem_ready=0.
  - In FETCH, IRWrite and PCUpdate are asserted only when mem_ready=1.
  - In MEMWRITE, MemWrite stays high for every wait cycle.
- MC_CTRL_MEM_WAIT_EN undefined: mem_ready is ignored and every state lasts exactly one cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, release → state=FETCH, with IRWrite=0 while in reset and IRWrite=1 on the first cycle after release.
- lw (op=0000011) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01; instr_done pulses in cycle 5.
- beq with zero=1, then bne (funct3=001) with zero=1 → PCWrite=1 in BRANCH for beq; PCWrite=0 in BRANCH for bne; each instruction takes 3 cycles.
- R-type funct3=000 with funct7b5=1 → ALUControl=1; funct3=101 with funct7b5=1 → ALUControl=7 when ALUCTRL_W=3 and 8 when ALUCTRL_W=4.
- op=1111111 → illegal_op pulses in DECODE, the next state is FETCH, and no write enable is asserted.
- With MC_CTRL_MEM_WAIT_EN: sw with mem_ready low for 2 cycles in MEMWRITE → MemWrite stays high 3 cycles, then FETCH.
